// File: rtl/s_mem_phase_scheduler.sv
// rtl/s_mem_phase_scheduler.sv - sequences init/shuffle/decrypt requesters onto one S-memory port
// Optional PHASE_WATCHDOG_EN adds a per-phase cycle watchdog and the ERROR state.
module s_mem_phase_scheduler #(
  parameter int WD_LIMIT = 1023
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       start,
  input  logic       key_changed,
  output logic       go_init,
  output logic       go_shuf,
  output logic       go_dec,
  input  logic       done_init,
  input  logic       done_shuf,
  input  logic       done_dec,
  input  logic [7:0] init_addr,
  input  logic [7:0] shuf_addr,
  input  logic [7:0] dec_addr,
  input  logic [7:0] init_wdata,
  input  logic [7:0] shuf_wdata,
  input  logic [7:0] dec_wdata,
  input  logic       init_wren,
  input  logic       shuf_wren,
  input  logic       dec_wren,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       mem_wren,
  output logic [2:0] phase,
  output logic       busy,
  output logic       all_done,
  output logic       wd_error
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_SHUF  = 3'd2,
    S_DEC   = 3'd3,
    S_FINAL = 3'd4,
    S_FLUSH = 3'd5,
    S_ERROR = 3'd6
  } state_t;

  state_t state, next_state;
  logic   in_phase;
  logic   entering;
  logic   wd_expired;

  assign in_phase = (state == S_INIT) || (state == S_SHUF) || (state == S_DEC);
  assign entering = (next_state != state) &&
                    ((next_state == S_INIT) || (next_state == S_SHUF) || (next_state == S_DEC));

`ifdef PHASE_WATCHDOG_EN
  logic [9:0] wd_cnt;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset)
      wd_cnt <= 10'd0;
    else if (entering)
      wd_cnt <= 10'd0;
    else if (in_phase)
      wd_cnt <= wd_cnt + 10'd1;
  end

  // wd_cnt is 0 in the first phase cycle, so expiry lands after exactly WD_LIMIT cycles
  assign wd_expired = in_phase && (wd_cnt == 10'(WD_LIMIT - 1));
`else
  logic unused_wd_limit;
  assign unused_wd_limit = (WD_LIMIT != 0);
  assign wd_expired      = 1'b0;
`endif

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset)
      state <= S_IDLE;
    else
      state <= next_state;
  end

  // key_changed outranks done and watchdog expiry
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (start) next_state = S_INIT;
      S_INIT: begin
        if (key_changed)     next_state = S_FLUSH;
        else if (done_init)  next_state = S_SHUF;
        else if (wd_expired) next_state = S_ERROR;
      end
      S_SHUF: begin
        if (key_changed)     next_state = S_FLUSH;
        else if (done_shuf)  next_state = S_DEC;
        else if (wd_expired) next_state = S_ERROR;
      end
      S_DEC: begin
        if (key_changed)     next_state = S_FLUSH;
        else if (done_dec)   next_state = S_FINAL;
        else if (wd_expired) next_state = S_ERROR;
      end
      S_FINAL: begin
        if (key_changed) next_state = S_FLUSH;
        else if (start)  next_state = S_INIT;
      end
      S_FLUSH: next_state = S_INIT;
`ifdef PHASE_WATCHDOG_EN
      S_ERROR: if (start) next_state = S_INIT;
`endif
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      go_init <= 1'b0;
      go_shuf <= 1'b0;
      go_dec  <= 1'b0;
    end else begin
      go_init <= entering && (next_state == S_INIT);
      go_shuf <= entering && (next_state == S_SHUF);
      go_dec  <= entering && (next_state == S_DEC);
    end
  end

  always_comb begin
    phase     = state;
    busy      = in_phase || (state == S_FLUSH);
    all_done  = (state == S_FINAL);
`ifdef PHASE_WATCHDOG_EN
    wd_error  = (state == S_ERROR);
`else
    wd_error  = 1'b0;
`endif
    mem_addr  = 8'd0;
    mem_wdata = 8'd0;
    mem_wren  = 1'b0;
    case (state)
      S_INIT: begin
        mem_addr  = init_addr;
        mem_wdata = init_wdata;
        mem_wren  = init_wren;
      end
      S_SHUF: begin
        mem_addr  = shuf_addr;
        mem_wdata = shuf_wdata;
        mem_wren  = shuf_wren;
      end
      S_DEC: begin
        mem_addr  = dec_addr;
        mem_wdata = dec_wdata;
        mem_wren  = dec_wren;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_s_mem_phase_scheduler.sv
// tb/tb_s_mem_phase_scheduler.sv - randomized and directed checks against a rule-level phase model
module tb_s_mem_phase_scheduler;

  localparam int WD_LIMIT = 1023;
`ifdef PHASE_WATCHDOG_EN
  localparam bit WD_ON = 1'b1;
`else
  localparam bit WD_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 0, key_changed = 0;
  logic       go_init, go_shuf, go_dec;
  logic       done_init = 0, done_shuf = 0, done_dec = 0;
  logic [7:0] init_addr = 0, shuf_addr = 0, dec_addr = 0;
  logic [7:0] init_wdata = 0, shuf_wdata = 0, dec_wdata = 0;
  logic       init_wren = 0, shuf_wren = 0, dec_wren = 0;
  logic [7:0] mem_addr, mem_wdata;
  logic       mem_wren;
  logic [2:0] phase;
  logic       busy, all_done, wd_error;

  int checks = 0;
  int errors = 0;

  int m_phase = 0;
  int m_next  = 0;
  int m_cnt   = 0;
  bit m_first = 0;
  bit seen_go_dec = 0;

  always #10 clk = ~clk;

  s_mem_phase_scheduler #(.WD_LIMIT(WD_LIMIT)) dut (
    .CLOCK_50(clk), .reset(reset), .start(start), .key_changed(key_changed),
    .go_init(go_init), .go_shuf(go_shuf), .go_dec(go_dec),
    .done_init(done_init), .done_shuf(done_shuf), .done_dec(done_dec),
    .init_addr(init_addr), .shuf_addr(shuf_addr), .dec_addr(dec_addr),
    .init_wdata(init_wdata), .shuf_wdata(shuf_wdata), .dec_wdata(dec_wdata),
    .init_wren(init_wren), .shuf_wren(shuf_wren), .dec_wren(dec_wren),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wren(mem_wren),
    .phase(phase), .busy(busy), .all_done(all_done), .wd_error(wd_error)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h phase_model=%0d t=%0t", tag, got, exp, m_phase, $time);
    end
  endtask

  // Expected outputs follow from which phase the model is in and whether it was just entered
  task automatic check_model();
    logic [7:0] ea, ed;
    logic       ew;
    ea = 0; ed = 0; ew = 0;
    if (m_phase == 1) begin ea = init_addr; ed = init_wdata; ew = init_wren; end
    if (m_phase == 2) begin ea = shuf_addr; ed = shuf_wdata; ew = shuf_wren; end
    if (m_phase == 3) begin ea = dec_addr;  ed = dec_wdata;  ew = dec_wren;  end
    check("phase",    32'(phase),    32'(m_phase));
    check("busy",     32'(busy),     32'((m_phase >= 1 && m_phase <= 3) || m_phase == 5));
    check("all_done", 32'(all_done), 32'(m_phase == 4));
    check("wd_error", 32'(wd_error), 32'(m_phase == 6));
    check("go_init",  32'(go_init),  32'(m_first && m_phase == 1));
    check("go_shuf",  32'(go_shuf),  32'(m_first && m_phase == 2));
    check("go_dec",   32'(go_dec),   32'(m_first && m_phase == 3));
    check("mem_addr", 32'(mem_addr), 32'(ea));
    check("mem_wdata",32'(mem_wdata),32'(ed));
    check("mem_wren", 32'(mem_wren), 32'(ew));
  endtask

  function automatic int model_next(input bit st, kc, di, ds, dd);
    int n;
    n = m_phase;
    if (kc && m_phase >= 1 && m_phase <= 4)                         n = 5;
    else if (m_phase == 5)                                          n = 1;
    else if (st && (m_phase == 0 || m_phase == 4 || (WD_ON && m_phase == 6))) n = 1;
    else if (m_phase == 1 && di)                                    n = 2;
    else if (m_phase == 2 && ds)                                    n = 3;
    else if (m_phase == 3 && dd)                                    n = 4;
    else if (WD_ON && m_phase >= 1 && m_phase <= 3 && m_cnt + 1 >= WD_LIMIT) n = 6;
    return n;
  endfunction

  task automatic tick_in(input bit st, kc, di, ds, dd, input bit rnd);
    @(negedge clk);
    start = st; key_changed = kc; done_init = di; done_shuf = ds; done_dec = dd;
    if (rnd) begin
      init_addr = 8'($urandom); shuf_addr = 8'($urandom); dec_addr = 8'($urandom);
      init_wdata = 8'($urandom); shuf_wdata = 8'($urandom); dec_wdata = 8'($urandom);
      init_wren = 1'($urandom); shuf_wren = 1'($urandom); dec_wren = 1'($urandom);
    end
    #1;
    check_model();
    seen_go_dec |= go_dec;
    m_next = model_next(st, kc, di, ds, dd);
  endtask

  task automatic tick_edge();
    bit entered;
    @(posedge clk);
    entered = (m_next != m_phase) && m_next >= 1 && m_next <= 3;
    if (entered) m_cnt = 0;
    else if (m_phase >= 1 && m_phase <= 3) m_cnt = m_cnt + 1;
    m_first = entered;
    m_phase = m_next;
  endtask

  task automatic tick(input bit st, kc, di, ds, dd);
    tick_in(st, kc, di, ds, dd, 1'b1);
    tick_edge();
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_phase",  32'(phase), 32'd0);
    check("rst_outs",   32'({go_init, go_shuf, go_dec, busy, all_done, wd_error, mem_wren}), 32'd0);
    check("rst_mem",    32'({mem_addr, mem_wdata}), 32'd0);
    reset = 1'b0;

    // Normal sequence: start@0, done_init@260, done_shuf@1100, done_dec@1300
    for (int i = 0; i <= 1305; i++) begin
      tick_in(i == 0, 1'b0, i == 260, i == 1100, i == 1300, 1'b1);
      if (i == 1)    check("seq_init",  32'(phase), 32'd1);
      if (i == 261)  check("seq_shuf",  32'(phase), 32'd2);
      if (i == 1101) check("seq_dec",   32'(phase), 32'd3);
      if (i == 1300) check("seq_nodone",32'(all_done), 32'd0);
      if (i == 1301) check("seq_final", 32'(all_done), 32'd1);
      tick_edge();
    end

    // Stray events: done_dec in INIT and start in SHUF change nothing
    tick(1, 0, 0, 0, 0);
    tick_in(1, 0, 0, 0, 1, 1'b1);
    check("stray_dec", 32'(phase), 32'd1);
    tick_edge();
    tick(0, 0, 1, 0, 0);
    tick_in(1, 0, 0, 0, 0, 1'b1);
    check("stray_start", 32'(phase), 32'd2);
    tick_edge();

    // Mux in SHUF with a competing init write
    tick_in(0, 0, 0, 0, 0, 1'b0);
    shuf_addr = 8'h3C; shuf_wdata = 8'hA5; shuf_wren = 1; init_wren = 1; #1;
    check("mux_addr",  32'(mem_addr),  32'h3C);
    check("mux_wdata", 32'(mem_wdata), 32'hA5);
    check("mux_wren",  32'(mem_wren),  32'd1);
    tick_edge();

    // Restart: key_changed together with done_shuf
    seen_go_dec = 0;
    tick(0, 1, 0, 1, 0);
    tick_in(0, 0, 0, 0, 0, 1'b1);
    shuf_wren = 1; init_wren = 1; dec_wren = 1; #1;
    check("flush_phase", 32'(phase), 32'd5);
    check("flush_wren",  32'(mem_wren), 32'd0);
    tick_edge();
    tick_in(0, 0, 0, 0, 0, 1'b1);
    check("restart_go",  32'(go_init), 32'd1);
    tick_edge();
    repeat (10) tick(0, 0, 0, 0, 0);
    check("no_go_dec", 32'(seen_go_dec), 32'd0);

    // FINAL mem outputs are zero
    tick(0, 0, 1, 0, 0);
    tick(0, 0, 0, 1, 0);
    tick(0, 0, 0, 0, 1);
    tick_in(0, 0, 0, 0, 0, 1'b0);
    init_wren = 1; shuf_wren = 1; dec_wren = 1; #1;
    check("final_mem", 32'({mem_addr, mem_wdata, mem_wren}), 32'd0);
    tick_edge();

    // Watchdog: no done_init for 1023 INIT cycles
    tick(1, 0, 0, 0, 0);
    repeat (WD_LIMIT) tick(0, 0, 0, 0, 0);
    tick_in(0, 0, 0, 0, 0, 1'b1);
    check("wd_phase", 32'(phase), WD_ON ? 32'd6 : 32'd1);
    check("wd_flag",  32'(wd_error), WD_ON ? 32'd1 : 32'd0);
    tick_edge();
    tick(1, 0, 0, 0, 0);
    tick(0, 0, 1, 0, 0);
    tick(0, 0, 0, 1, 0);

    // Async reset between edges in DEC
    tick_in(0, 0, 0, 0, 0, 1'b1);
    dec_wren = 1;
    #3 reset = 1'b1;
    #1;
    check("areset_phase", 32'(phase), 32'd0);
    check("areset_wren",  32'(mem_wren), 32'd0);
    check("areset_busy",  32'(busy), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    m_phase = 0; m_first = 0; m_cnt = 0;
    repeat (5) tick(0, 0, 0, 0, 0);
    check("post_reset_busy", 32'(busy), 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++)
      tick($urandom_range(0, 19) == 0, $urandom_range(0, 39) == 0,
           $urandom_range(0, 14) == 0, $urandom_range(0, 14) == 0,
           $urandom_range(0, 14) == 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
